multi_alarm_clock: RTL

- BCD 24-hour clock (HH:MM) with N independently programmable alarm channels.
- Each channel has an enable, a ring duration, a snooze function and a stop function.
- Time advances on an external one-per-minute `tick` strobe, not on every clock, so the block runs on the system clock.
- It supersedes the single-alarm clock on the lab board. Outputs drive the per-channel LEDs and a combined alarm LED.

---
 rtl/multi_alarm_clock.sv | 95 +++++++++
 1 files changed

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD 24-hour clock with N_ALARM independently programmable alarm channels.
// Each channel can ring for a fixed time, be snoozed and re-ring, or be stopped.
module multi_alarm_clock #(
  parameter int N_ALARM    = 4,
  parameter int RING_MIN   = 10,
  parameter int SNOOZE_MIN = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               set_time,
  input  logic [12:0]        time_in,
  input  logic               wr_en,
  input  logic [2:0]         wr_idx,
  input  logic [12:0]        wr_time,
  input  logic               wr_enable,
  input  logic               snooze,
  input  logic               stop,
  output logic [12:0]        cur_time,
  output logic [N_ALARM-1:0] ringing,
  output logic               led_on
);
  localparam int DW = $clog2((RING_MIN > SNOOZE_MIN ? RING_MIN : SNOOZE_MIN) + 1);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  logic [1:0] hr1;
  logic [3:0] hr0, min0;
  logic [2:0] min1;
  logic [12:0] next_time;
  logic c0, c1, c2, wrap, in_valid;
  assign {hr1, hr0, min1, min0} = cur_time;
  assign c0 = min0 == 4'd9;
  assign c1 = c0 && min1 == 3'd5;
  assign c2 = c1 && hr0 == 4'd9;
  assign wrap = c1 && hr1 == 2'd2 && hr0 == 4'd3;
  assign next_time = wrap ? 13'd0 : {c2 ? hr1 + 2'd1 : hr1,
                                     c2 ? 4'd0 : c1 ? hr0 + 4'd1 : hr0,
                                     c1 ? 3'd0 : c0 ? min1 + 3'd1 : min1,
                                     c0 ? 4'd0 : min0 + 4'd1};
  assign in_valid = time_in[12:11] <= 2'd2 && time_in[10:7] <= 4'd9 &&
                    !(time_in[12:11] == 2'd2 && time_in[10:7] > 4'd3) &&
                    time_in[6:4] <= 3'd5 && time_in[3:0] <= 4'd9;
  always_ff @(posedge clk or posedge rst)
    if (rst) cur_time <= '0;
    else if (set_time ? in_valid : tick) cur_time <= set_time ? time_in : next_time;
  for (genvar i = 0; i < N_ALARM; i++) begin : g_ch
    logic [12:0] alarm;
    logic en, hit, match, ring;
    state_t st, nst;
    logic [DW-1:0] dcnt, nd;
    assign hit = wr_en && wr_idx == 3'(i);
    assign match = tick && !set_time && en && next_time == alarm;
    assign ringing[i] = ring;
    // stop discards a same-cycle match even for an idle channel
    always_comb begin
      nst = st;
      nd = dcnt;
      if (hit || stop) begin
        nst = IDLE;
        nd = '0;
      end else if (st == RING && snooze) begin
        nst = SNOOZE;
        nd = '0;
      end else if (match) begin
        nst = RING;
        nd = '0;
      end else if (tick && st != IDLE) begin
        nd = dcnt + 1'b1;
        if (st == RING && nd == DW'(RING_MIN)) begin
          nst = IDLE;
          nd = '0;
        end else if (st == SNOOZE && nd == DW'(SNOOZE_MIN)) begin
          nst = RING;
          nd = '0;
        end
      end
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        alarm <= '0;
        en <= 1'b0;
        st <= IDLE;
        dcnt <= '0;
        ring <= 1'b0;
      end else begin
        if (hit) begin
          alarm <= wr_time;
          en <= wr_enable;
        end
        st <= nst;
        dcnt <= nd;
        ring <= nst == RING;
      end
  end
  assign led_on = |ringing;
endmodule
